// File: rtl/lcd_pkg.sv
// Shared sizes and FSM encoding for the LCD character buffer.
// No ports; imported by lcd_char_buffer.
package lcd_pkg;

    localparam int LCD_CHARS  = 32;
    localparam int LCD_POS_W  = 5;
    localparam int LCD_CHAR_W = 8;

    typedef enum logic [1:0] {
        ST_SCAN  = 2'd0,
        ST_OFFER = 2'd1,
        ST_CLEAR = 2'd2
    } lcd_state_e;

endpackage

// File: rtl/lcd_char_buffer.sv
// 2x16 LCD character store with dirty tracking; a scan pointer offers
// changed characters one at a time to an LCD driver over valid/ready.
// Ports: clk, sysrst (async, active-high), update/position/char_in (write),
//   char_valid/char_ready/char_pos/char_code (offer), busy.
// Build option LCD_BUF_CLEAR_EN adds input clear and a 32-cycle clear walk.
module lcd_char_buffer
    import lcd_pkg::*;
#(
    parameter logic [LCD_CHAR_W-1:0] CLR_CHAR = 8'h20
) (
    input  logic                  clk,
    input  logic                  sysrst,
    input  logic                  update,
    input  logic [LCD_POS_W-1:0]  position,
    input  logic [LCD_CHAR_W-1:0] char_in,
`ifdef LCD_BUF_CLEAR_EN
    input  logic                  clear,
`endif
    output logic                  char_valid,
    input  logic                  char_ready,
    output logic [LCD_POS_W-1:0]  char_pos,
    output logic [LCD_CHAR_W-1:0] char_code,
    output logic                  busy
);

    localparam logic [LCD_POS_W-1:0] LAST_POS = LCD_POS_W'(LCD_CHARS - 1);

    lcd_state_e                state_q, state_d;
    logic [LCD_POS_W-1:0]      ptr_q, ptr_d;
    logic                      valid_q, valid_d;
    logic [LCD_POS_W-1:0]      pos_q, pos_d;
    logic [LCD_CHAR_W-1:0]     code_q, code_d;
    logic [LCD_CHARS-1:0]      dirty_q, dirty_d;
    logic [LCD_CHAR_W-1:0]     store_q [LCD_CHARS];
    logic [LCD_CHAR_W-1:0]     store_d [LCD_CHARS];
    logic                      wr_en;
`ifdef LCD_BUF_CLEAR_EN
    logic                      pend_q, pend_d;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        pos_d   = pos_q;
        code_d  = code_q;
        dirty_d = dirty_q;
        store_d = store_q;
        wr_en   = update;
`ifdef LCD_BUF_CLEAR_EN
        pend_d  = pend_q;
`endif
        unique case (state_q)
            ST_SCAN: begin
`ifdef LCD_BUF_CLEAR_EN
                if (clear) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end else
`endif
                if (dirty_q[ptr_q]) begin
                    // Latch the pre-edge code; a same-edge write to this
                    // entry re-sets dirty below so it is offered again.
                    pos_d          = ptr_q;
                    code_d         = store_q[ptr_q];
                    dirty_d[ptr_q] = 1'b0;
                    valid_d        = 1'b1;
                    state_d        = ST_OFFER;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_OFFER: begin
`ifdef LCD_BUF_CLEAR_EN
                if (clear) pend_d = 1'b1;
`endif
                if (char_ready) begin
                    valid_d = 1'b0;
                    ptr_d   = ptr_q + 1'b1;
                    state_d = ST_SCAN;
`ifdef LCD_BUF_CLEAR_EN
                    if (pend_q || clear) begin
                        state_d = ST_CLEAR;
                        ptr_d   = '0;
                        pend_d  = 1'b0;
                    end
`endif
                end
            end
`ifdef LCD_BUF_CLEAR_EN
            ST_CLEAR: begin
                // Pointer doubles as the clear index; wrapping 31->0
                // leaves it at 0 for the repaint scan.
                wr_en          = 1'b0;
                store_d[ptr_q] = CLR_CHAR;
                dirty_d[ptr_q] = 1'b1;
                ptr_d          = ptr_q + 1'b1;
                if (ptr_q == LAST_POS) state_d = ST_SCAN;
            end
`endif
            default: begin
                state_d = ST_SCAN;
            end
        endcase
        if (wr_en) begin
            store_d[position] = char_in;
            dirty_d[position] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge sysrst) begin
        if (sysrst) begin
            state_q <= ST_SCAN;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            pos_q   <= '0;
            code_q  <= '0;
            dirty_q <= '1;
            for (int i = 0; i < LCD_CHARS; i++) store_q[i] <= CLR_CHAR;
`ifdef LCD_BUF_CLEAR_EN
            pend_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            pos_q   <= pos_d;
            code_q  <= code_d;
            dirty_q <= dirty_d;
            for (int i = 0; i < LCD_CHARS; i++) store_q[i] <= store_d[i];
`ifdef LCD_BUF_CLEAR_EN
            pend_q  <= pend_d;
`endif
        end
    end

    assign char_valid = valid_q;
    assign char_pos   = pos_q;
    assign char_code  = code_q;
    assign busy       = (|dirty_q) | (state_q != ST_SCAN);

endmodule
